// File: rtl/rob_multiport.sv
// rob_multiport: parametrised reorder buffer between rename/dispatch and the
// physical register free pool.
//
// Entries are allocated in program order (up to N_DISPATCH per cycle), marked
// done by out-of-order completion strobes (N_COMPLETE ports), and retired
// in order from the head (up to N_RETIRE per cycle). Retirement hands rd_old
// back to the free pool.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   disp_valid       per-lane dispatch request
//   disp_pc/rd/rd_old/regwrite   per-lane payload, lane i in slice i
//   disp_ready       room for N_DISPATCH entries (from the registered count)
//   disp_rob_num     index assigned to each lane, driven even for idle lanes
//   cmp_valid        per-port completion strobe
//   cmp_rob_num      per-port completing entry index
//   ret_valid        retire lane valid, packed from lane 0
//   ret_pc/rd/rd_old/regwrite    payload of each retiring entry
//   flush            synchronous squash of every entry (highest priority)
//   count            occupied entries
//   empty, full      count == 0, count == DEPTH
//
// Handshake: a dispatch lane transfers on a rising edge when disp_valid[i]
// and disp_ready are both high and flush is low. disp_ready depends only on
// registered state, never on disp_valid. Retire has no back-pressure: the
// consumer must take every ret_valid lane in the cycle it is shown.
module rob_multiport #(
  parameter int DEPTH      = 16,
  parameter int PTAG_W     = 6,
  parameter int N_DISPATCH = 2,
  parameter int N_COMPLETE = 3,
  parameter int N_RETIRE   = 2,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_DISPATCH-1:0]        disp_valid,
  input  logic [N_DISPATCH*32-1:0]     disp_pc,
  input  logic [N_DISPATCH*PTAG_W-1:0] disp_rd,
  input  logic [N_DISPATCH*PTAG_W-1:0] disp_rd_old,
  input  logic [N_DISPATCH-1:0]        disp_regwrite,
  output logic                         disp_ready,
  output logic [N_DISPATCH*IDX_W-1:0]  disp_rob_num,
  input  logic [N_COMPLETE-1:0]        cmp_valid,
  input  logic [N_COMPLETE*IDX_W-1:0]  cmp_rob_num,
  output logic [N_RETIRE-1:0]          ret_valid,
  output logic [N_RETIRE*32-1:0]       ret_pc,
  output logic [N_RETIRE*PTAG_W-1:0]   ret_rd,
  output logic [N_RETIRE*PTAG_W-1:0]   ret_rd_old,
  output logic [N_RETIRE-1:0]          ret_regwrite,
  input  logic                         flush,
  output logic [IDX_W:0]               count,
  output logic                         empty,
  output logic                         full
);

  localparam logic [IDX_W:0] DEPTH_W = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] NDISP_W = (IDX_W+1)'(N_DISPATCH);
  localparam logic [IDX_W:0] ONE     = {{IDX_W{1'b0}}, 1'b1};

  // Entry state. valid/done are reset; the payload is only meaningful while
  // valid is set, so it carries no reset.
  logic [DEPTH-1:0]  ent_valid, ent_done, ent_regwrite;
  logic [31:0]       ent_pc     [DEPTH];
  logic [PTAG_W-1:0] ent_rd     [DEPTH];
  logic [PTAG_W-1:0] ent_rd_old [DEPTH];

  // Full-width pointers: the MSB is the wrap bit.
  logic [IDX_W:0] head, tail, count_q;

  logic [DEPTH-1:0]      valid_nxt, done_nxt;
  logic [N_DISPATCH-1:0] disp_acc;
  logic [IDX_W-1:0]      disp_slot [N_DISPATCH];
  logic [IDX_W:0]        disp_cnt, disp_num;
  logic [IDX_W-1:0]      ret_slot  [N_RETIRE];
  logic [IDX_W:0]        ret_cnt;
  logic                  ret_stop;
  logic [IDX_W-1:0]      cmp_idx;

  assign count = count_q;
  assign empty = (head == tail);
  assign full  = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
  assign disp_ready = (DEPTH_W - count_q) >= NDISP_W;

  // Dispatch compaction: each lane takes tail plus the number of requesting
  // lanes below it, so idle lanes never leave holes in the buffer.
  always_comb begin
    disp_cnt     = '0;
    disp_acc     = '0;
    disp_rob_num = '0;
    for (int i = 0; i < N_DISPATCH; i++) begin
      disp_slot[i] = tail[IDX_W-1:0] + disp_cnt[IDX_W-1:0];
      disp_rob_num[i*IDX_W +: IDX_W] = disp_slot[i];
      disp_acc[i] = disp_valid[i] & disp_ready;
      if (disp_valid[i]) disp_cnt = disp_cnt + ONE;
    end
    disp_num = disp_ready ? disp_cnt : '0;
  end

  // Retire: walk from the head and stop at the first entry that is not both
  // valid and done, so lanes are always contiguous from lane 0.
  always_comb begin
    ret_valid    = '0;
    ret_pc       = '0;
    ret_rd       = '0;
    ret_rd_old   = '0;
    ret_regwrite = '0;
    ret_cnt      = '0;
    ret_stop     = flush;
    for (int k = 0; k < N_RETIRE; k++) begin
      ret_slot[k] = head[IDX_W-1:0] + IDX_W'(k);
      ret_pc[k*32 +: 32]             = ent_pc[ret_slot[k]];
      ret_rd[k*PTAG_W +: PTAG_W]     = ent_rd[ret_slot[k]];
      ret_rd_old[k*PTAG_W +: PTAG_W] = ent_rd_old[ret_slot[k]];
      ret_regwrite[k]                = ent_regwrite[ret_slot[k]];
      if (!ret_stop && ent_valid[ret_slot[k]] && ent_done[ret_slot[k]]) begin
        ret_valid[k] = 1'b1;
        ret_cnt      = ret_cnt + ONE;
      end else begin
        ret_stop = 1'b1;
      end
    end
  end

  // Next valid/done. Completions to empty slots are dropped; retire clears
  // after completion so a late duplicate strobe cannot resurrect a retired
  // entry; dispatch only targets free slots so it never overlaps retire.
  always_comb begin
    valid_nxt = ent_valid;
    done_nxt  = ent_done;
    cmp_idx   = '0;
    for (int c = 0; c < N_COMPLETE; c++) begin
      cmp_idx = cmp_rob_num[c*IDX_W +: IDX_W];
      if (cmp_valid[c] && ent_valid[cmp_idx]) done_nxt[cmp_idx] = 1'b1;
    end
    for (int k = 0; k < N_RETIRE; k++) begin
      if (ret_valid[k]) begin
        valid_nxt[ret_slot[k]] = 1'b0;
        done_nxt[ret_slot[k]]  = 1'b0;
      end
    end
    for (int i = 0; i < N_DISPATCH; i++) begin
      if (disp_acc[i]) begin
        valid_nxt[disp_slot[i]] = 1'b1;
        done_nxt[disp_slot[i]]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count_q   <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count_q   <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else begin
      head      <= head + ret_cnt;
      tail      <= tail + disp_num;
      count_q   <= count_q + disp_num - ret_cnt;
      ent_valid <= valid_nxt;
      ent_done  <= done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_DISPATCH; i++) begin
      if (disp_acc[i] && !flush) begin
        ent_pc[disp_slot[i]]       <= disp_pc[i*32 +: 32];
        ent_rd[disp_slot[i]]       <= disp_rd[i*PTAG_W +: PTAG_W];
        ent_rd_old[disp_slot[i]]   <= disp_rd_old[i*PTAG_W +: PTAG_W];
        ent_regwrite[disp_slot[i]] <= disp_regwrite[i];
      end
    end
  end

endmodule
